sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO built on a dual-port memory array with a registered read port, replacing the bare RAM plus external pointer logic in the sync_fifo path. It tracks fill level, raises full/empty and programmable almost-full/almost-empty flags, and flags illegal accesses with sticky error bits. It also supports a synchronous flush.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits.
DEPTH, 16, number of entries; must be a power of 2 and at least 4.
ADDR_WIDTH, 4, log2(DEPTH).
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH-1).
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (1..DEPTH-1).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous flush; empties the FIFO and clears error flags.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  write data, sampled with wr_en.
rd_en  input  1  read request.
rd_data  output  DATA_WIDTH  registered read data.
rd_valid  output  1  rd_data holds a newly popped word this cycle.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.
count  output  ADDR_WIDTH+1  current number of stored words, 0..DEPTH.
overflow  output  1  sticky: a write was attempted while full.
underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0. This gives empty = 1, almost_empty = 1, full = 0 and almost_full = 0. Memory contents are not reset.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0. count is a separate (ADDR_WIDTH+1)-bit register.
- Write is accepted iff wr_en && !full && !clr. An accepted write stores mem[wr_ptr] = wr_data and increments wr_ptr.
- Read is accepted iff rd_en && !empty && !clr. An accepted read loads rd_data <= mem[rd_ptr] and increments rd_ptr.
  - Latency is 1 cycle: rd_valid = 1 in the cycle after acceptance, 0 otherwise.
  - rd_data holds its last value when no read is accepted.
- count update:
  - +1 when only a write is accepted.
  - -1 when only a read is accepted.
  - Unchanged when both or neither are accepted.
- All flags are combinational decodes of the registered count, so they reflect state after the previous edge.
- Simultaneous read and write when empty: the write is accepted and the read is rejected (underflow set). The new word is readable from the next cycle.
- Simultaneous read and write when full: the read is accepted and the write is rejected (overflow set). There is no pass-through, so the FIFO never reads and writes the same address in one cycle.
- Simultaneous read and write when 0 < count < DEPTH: both are accepted, count is unchanged, and the pointers advance independently.
- overflow sets on wr_en && full; underflow sets on rd_en && empty. Both stay set until clr or reset.
- clr (synchronous, highest priority after reset):
  - Next state: wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0, rd_valid = 0.
  - rd_data is held; wr_en and rd_en are ignored in that cycle.
- Reset asserted mid-operation discards all contents immediately. The first write after rst_n deasserts lands at address 0.

Test Plan:
1. Defaults. Reset, then write 0x00..0x0F in 16 cycles → full = 1 and count = 16 after the 16th edge. almost_full first rises when count = 12. Then read 16 → rd_data sequence 0x00..0x0F, each with rd_valid = 1 one cycle after rd_en. Ends with empty = 1 and almost_empty = 1.
2. Wrap-around and concurrency. Write 10 words, read 10, then write 0xA0..0xA9 while reading continuously from the second cycle. Data out must be 0xA0..0xA9 in order across the pointer wrap, with count staying at 1.
3. Full boundary. Fill 16 words, then assert wr_en = 1 (data 0xEE) with rd_en = 1 in the same cycle. Required: one read accepted, write rejected, count = 15, overflow = 1, and 0xEE never appears at the output.
4. Empty boundary. From empty, assert rd_en = 1 with wr_en = 1 (data 0x55). Required: underflow = 1, count = 1, rd_valid = 0 that cycle. The next read returns 0x55.
5. Flush. With 7 words stored and overflow = 1, pulse clr together with wr_en = 1. Required next cycle: count = 0, empty = 1, overflow = 0, and the write is ignored.
6. Async reset. Assert rst_n = 0 mid-burst, away from a clock edge. Required: flags and count change immediately (count = 0, empty = 1, rd_valid = 0). After release, a write of 0x3C followed by a read returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read port, level flags,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full         = (count == CNT_DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // Full/empty gating means a read and write never hit one address together.
    assign wr_ok = wr_en && !full && !clr;
    assign rd_ok = rd_en && !empty && !clr;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_ok;
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with default parameters.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH(16),
        .ADDR_WIDTH(4),
        .AF_LEVEL(12),
        .AE_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c, input logic w, input logic [7:0] d,
                        input logic r);
        clr     = c;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdd", rd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: fill 0x00..0x0F then drain
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i), 0);
            chk("t1_wcount", count, i + 1);
            chk("t1_af", almost_full, (i + 1 >= 12) ? 1 : 0);
            chk("t1_full", full, (i == 15) ? 1 : 0);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            chk("t1_rdv", rd_valid, 1);
            chk("t1_rdd", rd_data, i);
            chk("t1_rcount", count, 15 - i);
        end
        step(0, 0, 8'h00, 0);
        chk("t1_rdv_idle", rd_valid, 0);
        chk("t1_empty", empty, 1);
        chk("t1_ae", almost_empty, 1);

        // 2: advance pointers to 10, then stream across the wrap
        for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 1);
            chk("t2_pre", rd_data, 8'h10 + i);
        end
        step(0, 1, 8'hA0, 0);
        chk("t2_cnt1", count, 1);
        for (int i = 1; i < 10; i++) begin
            step(0, 1, 8'(8'hA0 + i), 1);
            chk("t2_rdv", rd_valid, 1);
            chk("t2_rdd", rd_data, 8'hA0 + i - 1);
            chk("t2_count", count, 1);
        end
        step(0, 0, 8'h00, 1);
        chk("t2_last", rd_data, 8'hA9);
        chk("t2_end_cnt", count, 0);

        // 3: write+read while full
        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h20 + i), 0);
        chk("t3_full", full, 1);
        step(0, 1, 8'hEE, 1);
        chk("t3_rdv", rd_valid, 1);
        chk("t3_rdd", rd_data, 8'h20);
        chk("t3_count", count, 15);
        chk("t3_ovf", overflow, 1);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            chk("t3_drain", rd_data, 8'h20 + i);
        end
        chk("t3_empty", empty, 1);

        // 4: write+read while empty
        step(0, 1, 8'h55, 1);
        chk("t4_unf", underflow, 1);
        chk("t4_count", count, 1);
        chk("t4_rdv", rd_valid, 0);
        step(0, 0, 8'h00, 1);
        chk("t4_rdd", rd_data, 8'h55);
        chk("t4_rdv2", rd_valid, 1);

        // 5: flush with write
        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h70 + i), 0);
        chk("t5_pre_cnt", count, 7);
        chk("t5_pre_ovf", overflow, 1);
        step(1, 1, 8'h99, 0);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_ovf", overflow, 0);
        chk("t5_unf", underflow, 0);
        chk("t5_rdv", rd_valid, 0);
        chk("t5_hold", rd_data, 8'h55);
        step(0, 0, 8'h00, 0);
        chk("t5_ignored", count, 0);

        // 6: async reset mid-burst
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0);
        step(0, 0, 8'h00, 1);
        chk("t6_pre_rdv", rd_valid, 1);
        chk("t6_pre_cnt", count, 4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_rdv", rd_valid, 0);
        rd_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, 8'h3C, 0);
        chk("t6_wcnt", count, 1);
        step(0, 0, 8'h00, 1);
        chk("t6_rdd", rd_data, 8'h3C);
        chk("t6_rdv2", rd_valid, 1);
        step(0, 0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
